// File: rtl/switch_pkg.sv
// Shared constants and helpers for the push-button conditioning path.
// Switch inputs are active-low; outputs are active-high.
package switch_pkg;

    localparam logic SW_ACTIVE_LEVEL = 1'b0;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;
    localparam int DEFAULT_SYNC_STAGES = 2;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: synchroniser, stability counter,
// debounced state and one-cycle edge strobes.
module switch_debounce_ch
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic switch_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic RELEASED = ~SW_ACTIVE_LEVEL;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_n_q, stable_n_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   synced_n;

    assign synced_n = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], switch_n_i};
        stable_n_d = stable_n_q;
        cnt_d      = cnt_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        if (synced_n == stable_n_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Level held long enough: accept it and strobe the edge.
            stable_n_d = synced_n;
            cnt_d      = '0;
            press_d    = (synced_n == SW_ACTIVE_LEVEL);
            rel_d      = (synced_n != SW_ACTIVE_LEVEL);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= {SYNC_STAGES{RELEASED}};
            stable_n_q <= RELEASED;
            cnt_q      <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            stable_n_q <= stable_n_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
        end
    end

    assign pressed_o       = (stable_n_q == SW_ACTIVE_LEVEL);
    assign press_pulse_o   = press_q;
    assign release_pulse_o = rel_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW raw active-low push-buttons into clean
// active-high levels with press/release strobes.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int N_SW = 3,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] switch_n,
    output logic [N_SW-1:0] pressed,
    output logic [N_SW-1:0] press_pulse,
    output logic [N_SW-1:0] release_pulse
);

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        switch_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i          (clk),
            .rst_i          (rst),
            .switch_n_i     (switch_n[i]),
            .pressed_o      (pressed[i]),
            .press_pulse_o  (press_pulse[i]),
            .release_pulse_o(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and random checks of switch_debouncer against a
// sliding-window model of the raw switch history.
module tb_switch_debouncer;

    localparam int N = 3;
    localparam int SYNC = 2;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] switch_n = '1;
    logic [N-1:0] pressed, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;

    switch_debouncer #(
        .N_SW(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .switch_n(switch_n),
        .pressed(pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Model: a new level is accepted at an edge when the last DEB
    // samples that have reached the synchroniser output all
    // disagree with the current debounced level.
    bit           hist [N][$];
    logic [N-1:0] m_stable_n = '1;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel = '0;

    task automatic model_edge(input logic [N-1:0] sw, input bit r);
        for (int c = 0; c < N; c++) begin
            if (r) begin
                hist[c] = {};
                repeat (SYNC + DEB) hist[c].push_back(1'b1);
                m_stable_n[c] = 1'b1;
                m_press[c] = 1'b0;
                m_rel[c] = 1'b0;
            end else begin
                int len = hist[c].size();
                bit flip = 1'b1;
                for (int j = len - SYNC - DEB + 1; j <= len - SYNC; j++)
                    if (hist[c][j] == m_stable_n[c]) flip = 1'b0;
                m_press[c] = 1'b0;
                m_rel[c] = 1'b0;
                if (flip) begin
                    m_stable_n[c] = ~m_stable_n[c];
                    m_press[c] = ~m_stable_n[c];
                    m_rel[c] = m_stable_n[c];
                end
                hist[c].push_back(sw[c]);
                if (hist[c].size() > 32) void'(hist[c].pop_front());
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [N-1:0] sw, input bit r);
        switch_n = sw;
        rst = r;
        @(posedge clk);
        model_edge(sw, r);
        #1;
        chk("pressed", pressed, ~m_stable_n);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        if (|(press_pulse & release_pulse))
            chk("pulse_exclusive", press_pulse & release_pulse, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick('1, 1'b0);
    endtask

    int           rise, npulse, ridx;
    int           seq [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    logic [N-1:0] lvl;
    int           hold [N];
    bit           r;

    initial begin
        // Reset defaults
        repeat (3) tick('1, 1'b1);
        chk("reset_pressed", pressed, 3'b000);
        idle(2);

        // Clean press on channel 0
        rise = -1; npulse = 0; ridx = -1;
        for (int i = 0; i < 8; i++) begin
            tick(3'b110, 1'b0);
            if (pressed[0] && rise < 0) rise = i;
            if (press_pulse[0]) begin npulse++; ridx = i; end
        end
        chk_int("clean_rise_edge", rise, 5);
        chk_int("clean_pulse_edge", ridx, 5);
        chk_int("clean_pulse_count", npulse, 1);
        chk("clean_others", {1'b0, pressed[2:1]}, 3'b000);
        idle(10);

        // Glitch of 3 edges on channel 1 is rejected
        npulse = 0;
        repeat (3) tick(3'b101, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick('1, 1'b0);
            npulse += int'(press_pulse[1]) + int'(pressed[1]);
        end
        chk_int("glitch3_activity", npulse, 0);

        // Exactly 4 edges is accepted
        npulse = 0;
        repeat (4) tick(3'b101, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick('1, 1'b0);
            npulse += int'(press_pulse[1]);
        end
        chk_int("glitch4_press_count", npulse, 1);

        // Bouncy release on channel 2
        repeat (8) tick(3'b011, 1'b0);
        chk("bounce_pre_pressed", {2'b0, pressed[2]}, 3'b001);
        npulse = 0; ridx = -1;
        for (int i = 0; i < 15; i++) begin
            tick({(i < 9) ? seq[i][0] : 1'b1, 2'b11}, 1'b0);
            if (release_pulse[2]) begin npulse++; ridx = i; end
        end
        chk_int("bounce_release_count", npulse, 1);
        chk_int("bounce_release_edge", ridx, 10);
        chk("bounce_post_pressed", {2'b0, pressed[2]}, 3'b000);
        idle(4);

        // All channels simultaneously
        npulse = 0; ridx = -1;
        for (int i = 0; i < 8; i++) begin
            tick(3'b000, 1'b0);
            if (press_pulse != 3'b000) npulse++;
            if (press_pulse == 3'b111) ridx = i;
        end
        chk_int("simul_pulse_cycles", npulse, 1);
        chk_int("simul_pulse_edge", ridx, 5);
        idle(10);

        // Reset while channel 0 count is partway
        repeat (4) tick(3'b110, 1'b0);
        tick(3'b110, 1'b1);
        chk("midreset_no_pulse", press_pulse, 3'b000);
        rise = -1; npulse = 0;
        for (int i = 0; i < 8; i++) begin
            tick(3'b110, 1'b0);
            if (pressed[0] && rise < 0) rise = i;
            npulse += int'(press_pulse[0]);
        end
        chk_int("midreset_rise_edge", rise, 5);
        chk_int("midreset_pulse_count", npulse, 1);
        idle(10);

        // Held through reset
        repeat (3) tick(3'b110, 1'b1);
        rise = -1; npulse = 0;
        for (int i = 0; i < 8; i++) begin
            tick(3'b110, 1'b0);
            if (pressed[0] && rise < 0) rise = i;
            npulse += int'(press_pulse[0]);
        end
        chk_int("held_rise_edge", rise, 5);
        chk_int("held_pulse_count", npulse, 1);
        idle(10);

        // Random bouncing with occasional resets
        lvl = '1;
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    lvl[c] = 1'($urandom_range(1, 0));
                    hold[c] = $urandom_range(7, 1);
                end
                hold[c]--;
            end
            r = ($urandom_range(99, 0) == 0);
            tick(lvl, r);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the board push-buttons.
- Takes raw, asynchronous, active-low switch inputs, synchronises them to clk and debounces them.
- Outputs clean active-high "pressed" levels plus one-cycle press and release pulses.
- The LED/control logic consumes these directly, so it no longer handles raw switch polarity or bounce.

Parameters:
- N_SW, 3: number of switch channels.
- SYNC_STAGES, 2: flip-flop synchroniser depth per channel. Must be ≥2.
- DEBOUNCE_CYCLES, 240000: consecutive stable cycles required to accept a new level. Default is 20 ms at 12 MHz. Must be ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- switch_n  input  N_SW  raw switches, active low (0 = pressed), asynchronous to clk.
- pressed  output  N_SW  debounced level, active high (1 = pressed).
- press_pulse  output  N_SW  one-cycle strobe when pressed[i] goes 0→1.
- release_pulse  output  N_SW  one-cycle strobe when pressed[i] goes 1→0.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst is synchronous and active-high.
  - All state updates on the rising edge of clk.
- Channels are fully independent; there is no cross-channel interaction.
- Reset (rst=1 at an edge):
  - Synchroniser flops ← 1 (released).
  - Stable state ← released.
  - Counter ← 0.
  - pressed = 0, press_pulse = 0, release_pulse = 0.
- Synchroniser: SYNC_STAGES-deep shift of switch_n[i]. The last stage is synced_n[i].
- Debounce state per channel: stable_n (1 = released), counter cnt with width $clog2(DEBOUNCE_CYCLES).
- Per edge, when rst=0:
  - If synced_n == stable_n: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable_n ← synced_n, cnt ← 0, and the matching pulse is asserted for that one cycle.
  - Else: cnt ← cnt+1.
- Outputs:
  - pressed = !stable_n, registered.
  - press_pulse and release_pulse are registered and high for exactly one cycle per accepted transition.
  - press_pulse and release_pulse are never both high on the same channel.
- Latency: a raw change held steady is reflected on pressed at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new raw value. This is 6 edges with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Glitch rejection:
  - Any excursion of synced_n shorter than DEBOUNCE_CYCLES cycles returns cnt to 0, and pressed does not change.
  - An excursion of exactly DEBOUNCE_CYCLES cycles is accepted.
- Bounce: each return to the stable level restarts qualification from cnt=0. There is no accumulation across bounces.
- Switch held pressed through reset: after rst deasserts, the press is qualified normally. pressed rises and press_pulse fires once, after the standard latency measured from the first post-reset edge.
- Reset mid-count: any partial count is discarded, and no pulse is issued in the reset cycle.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Decomposition:
- Shared package switch_pkg:
  - SW_ACTIVE_LEVEL = 1'b0
  - DEFAULT_DEBOUNCE_CYCLES = 240000
  - DEFAULT_SYNC_STAGES = 2
  - function cnt_width(n) = $clog2(n)
- Sub-module switch_debounce_ch: one channel, containing the synchroniser, counter, stable state and pulse registers.
- switch_debouncer instantiates N_SW copies with a generate loop.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, N_SW=3.
1. Reset defaults: assert rst for 3 cycles with switch_n=3'b111 → pressed=000, press_pulse=000, release_pulse=000 during and after reset.
2. Clean press:
   - Stimulus: switch_n[0] falls before edge E0 and is held low.
   - Response: pressed[0] rises at E5; press_pulse[0]=1 only in the cycle after E5; channels 1 and 2 unchanged.
3. Glitch rejection and boundary:
   - switch_n[1] low for 3 edges then high → pressed[1] stays 0, no pulse.
   - Repeat with 4 edges low → pressed[1]=1 with one press_pulse.
4. Bouncy release:
   - Stimulus: with pressed[2]=1, switch_n[2] toggles 1,0,1,1,0,1,1,1,1 on successive edges, then stays 1.
   - Response: exactly one release_pulse[2], occurring 4 edges after the final synchronised rise; pressed[2]=0 afterwards.
5. Simultaneous channels and reset mid-count:
   - All three switch_n fall together → all pressed bits rise on the same edge with press_pulse=111 for one cycle.
   - Separately, assert rst while cnt=2 → cnt cleared, no pulse, then re-qualification from scratch.
6. Held through reset: hold switch_n[0]=0 while deasserting rst → pressed[0] rises 6 edges after the first post-reset edge, with a single press_pulse[0].
